// File: rtl/gui_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gui_pkg
// Brief    : Shared GUI definitions: color codes, hit classes, palette
//            panel layout and stroke-width limits.
// Revision : 1.0 - initial release
// ============================================================================
package gui_pkg;

   // Color codes shared with the panel renderer
   localparam logic [3:0] COLOR_BLACK   = 4'd0;
   localparam logic [3:0] COLOR_WHITE   = 4'd1;
   localparam logic [3:0] COLOR_RED     = 4'd2;
   localparam logic [3:0] COLOR_GREEN   = 4'd3;
   localparam logic [3:0] COLOR_BLUE    = 4'd4;
   localparam logic [3:0] COLOR_CYAN    = 4'd5;
   localparam logic [3:0] COLOR_MAGENTA = 4'd6;
   localparam logic [3:0] COLOR_YELLOW  = 4'd7;
   localparam logic [3:0] COLOR_GRAY    = 4'd8;
   localparam int         NUM_COLORS    = 9;

   // What a cursor position lands on
   typedef enum logic [2:0] {
      NONE      = 3'd0,
      COLOR     = 3'd1,
      WIDTH_DEC = 3'd2,
      WIDTH_INC = 3'd3,
      CANVAS    = 3'd4
   } hit_t;

   // Swatch column: swatch i spans y = SWATCH_Y0 + i*PITCH .. + SWATCH_H-1
   localparam int SWATCH_X0    = 20;
   localparam int SWATCH_X1    = 80;
   localparam int SWATCH_Y0    = 100;
   localparam int SWATCH_PITCH = 40;
   localparam int SWATCH_H     = 30;

   // Width buttons share one row
   localparam int BTN_Y0 = 480;
   localparam int BTN_Y1 = 509;
   localparam int DEC_X0 = 20;
   localparam int DEC_X1 = 45;
   localparam int INC_X0 = 55;
   localparam int INC_X1 = 80;

   // Stroke width limits and power-up state
   localparam logic [2:0] WIDTH_MIN   = 3'd1;
   localparam logic [2:0] WIDTH_MAX   = 3'd7;
   localparam logic [2:0] WIDTH_RESET = 3'd2;
   localparam logic [3:0] COLOR_RESET = COLOR_WHITE;

   // One saturating step of the stroke width in the requested direction
   function automatic logic [2:0] width_step(input logic [2:0] width, input logic inc);
      logic [2:0] w_result;
      w_result = width;
      if (inc) begin
         if (width < WIDTH_MAX) w_result = width + 3'd1;
      end else begin
         if (width > WIDTH_MIN) w_result = width - 3'd1;
      end
      return w_result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gui_hit_decode.sv
`default_nettype none
// ============================================================================
// Module   : gui_hit_decode
// Brief    : Combinational hit test of a cursor position against the palette
//            panel layout. Returns the hit class and, for swatches, the
//            color index.
// Revision : 1.0 - initial release
// ============================================================================
module gui_hit_decode
   import gui_pkg::*;
#(
   parameter int PANEL_W = 100
) (
   input  logic [10:0] cursor_x,
   input  logic [9:0]  cursor_y,
   input  logic        cursor_valid,
   output hit_t        hit,
   output logic [3:0]  color_idx
);

   int w_x;
   int w_y;

   // Classify the position; everything inside the panel that is not a
   // swatch or button is NONE, everything right of it is canvas
   always_comb begin
      w_x       = int'(cursor_x);
      w_y       = int'(cursor_y);
      hit       = NONE;
      color_idx = 4'd0;
      if (!cursor_valid) begin
         hit = NONE;
      end else if (w_x > PANEL_W) begin
         hit = CANVAS;
      end else begin
         if (w_x >= SWATCH_X0 && w_x <= SWATCH_X1) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
               if (w_y >= SWATCH_Y0 + SWATCH_PITCH * i &&
                   w_y <= SWATCH_Y0 + SWATCH_PITCH * i + SWATCH_H - 1) begin
                  hit       = COLOR;
                  color_idx = 4'(i);
               end
            end
         end
         if (w_y >= BTN_Y0 && w_y <= BTN_Y1) begin
            if (w_x >= DEC_X0 && w_x <= DEC_X1) begin
               hit = WIDTH_DEC;
            end else if (w_x >= INC_X0 && w_x <= INC_X1) begin
               hit = WIDTH_INC;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gui_palette_select.sv
`default_nettype none
// ============================================================================
// Module   : gui_palette_select
// Brief    : Palette panel input controller. Debounces the click level,
//            latches the hit target once a press is accepted, commits one
//            color/width action per press and drives pen_down for canvas
//            presses.
// Revision : 1.0 - initial release
// ============================================================================
module gui_palette_select
   import gui_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int PANEL_W  = 100
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] cursor_x,
   input  logic [9:0]  cursor_y,
   input  logic        cursor_valid,
   input  logic        click_in,
   output logic [3:0]  cursor_color,
   output logic [2:0]  stroke_width,
   output logic        update_out,
   output logic        pen_down
);

   localparam int c_CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
   // Counter value that, together with one more matching sample, completes
   // a debounce window
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      ACT     = 3'd2,
      HELD    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [c_CNT_W-1:0]  w_cnt_next;
   logic                w_latch;
   hit_t                w_hit;
   logic [3:0]          w_hit_idx;
   hit_t                r_tgt;
   logic [3:0]          r_tgt_idx;
   hit_t                w_tgt_next;
   logic                w_pen_next;
   logic [3:0]          r_color;
   logic [2:0]          r_width;
   logic                r_update;
   logic                r_pen;

   gui_hit_decode #(
      .PANEL_W      (PANEL_W)
   ) u_hit_decode (
      .cursor_x     (cursor_x),
      .cursor_y     (cursor_y),
      .cursor_valid (cursor_valid),
      .hit          (w_hit),
      .color_idx    (w_hit_idx)
   );

   // State, debounce counter and the target latched at press acceptance
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_tgt     <= NONE;
         r_tgt_idx <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_latch) begin
            r_tgt     <= w_hit;
            r_tgt_idx <= w_hit_idx;
         end
      end
   end

   // Debounce sequencing; the target is captured on the edge entering ACT
   // so that later cursor motion cannot change the press outcome
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_latch      = 1'b0;
      case (r_state)
         IDLE: begin
            if (click_in) begin
               if (DEBOUNCE == 1) begin
                  w_state_next = ACT;
                  w_cnt_next   = '0;
                  w_latch      = 1'b1;
               end else begin
                  w_state_next = ARM;
                  w_cnt_next   = c_CNT_ONE;
               end
            end
         end
         ARM: begin
            if (!click_in) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_next = ACT;
               w_cnt_next   = '0;
               w_latch      = 1'b1;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end
         ACT: begin
            w_state_next = HELD;
            w_cnt_next   = '0;
         end
         HELD: begin
            if (!click_in) begin
               if (DEBOUNCE == 1) begin
                  w_state_next = IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = RELEASE;
                  w_cnt_next   = c_CNT_ONE;
               end
            end
         end
         RELEASE: begin
            if (click_in) begin
               w_state_next = HELD;
               w_cnt_next   = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // pen_down looks at the target as it will be after this edge, so a canvas
   // press shows pen_down in the same cycle the FSM reaches ACT
   always_comb begin
      w_tgt_next = w_latch ? w_hit : r_tgt;
      w_pen_next = (w_state_next == ACT || w_state_next == HELD ||
                    w_state_next == RELEASE) &&
                   (w_tgt_next == CANVAS) && cursor_valid;
   end

   // Commit the latched action on the edge leaving ACT
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_color  <= COLOR_RESET;
         r_width  <= WIDTH_RESET;
         r_update <= 1'b0;
         r_pen    <= 1'b0;
      end else begin
         r_update <= 1'b0;
         r_pen    <= w_pen_next;
         if (r_state == ACT) begin
            case (r_tgt)
               COLOR: begin
                  r_color  <= r_tgt_idx;
                  r_update <= 1'b1;
               end
               WIDTH_DEC: begin
                  r_width  <= width_step(r_width, 1'b0);
                  r_update <= 1'b1;
               end
               WIDTH_INC: begin
                  r_width  <= width_step(r_width, 1'b1);
                  r_update <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign cursor_color = r_color;
   assign stroke_width = r_width;
   assign update_out   = r_update;
   assign pen_down     = r_pen;

endmodule
`default_nettype wire
